pipeline_ctrl: RTL

Central stall/flush/trap sequencer for the 5-stage pipeline. It combines the load-use stall request, the branch/jump redirects, data-memory wait and trap events (EX-stage exceptions, external IRQ, bus timeout) into one prioritised set of per-stage write-enable and flush strobes. It also drives PC source selection, EPC capture and the kernel-mode flag.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_stall_perf_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush/trap sequencer.
package pipeline_ctrl_pkg;

  localparam int unsigned WAIT_W = 8;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_TRAP = 2'b10;
  localparam logic [1:0] PCSEL_EPC  = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXC  = 2'b01;
  localparam logic [1:0] CAUSE_IRQ  = 2'b10;
  localparam logic [1:0] CAUSE_BUS  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN     = 2'd0;
  localparam state_t ST_FREEZE  = 2'd1;
  localparam state_t ST_BUS_ERR = 2'd2;

endpackage

// File: rtl/pipeline_ctrl_stall_perf_counter.sv
// Saturating performance counter with an increment enable.
module stall_perf_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Prioritised stall/flush/trap sequencer: per-stage enables, flushes, PC select,
// EPC capture and kernel-mode tracking.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_use_stall,
  input  logic                   branch_taken,
  input  logic                   jump_id,
  input  logic                   exception_ex,
  input  logic                   irq,
  input  logic                   eret_id,
  input  logic                   mem_busy,
  output logic                   pc_we,
  output logic                   if_id_we,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_we,
  output logic                   ex_mem_flush,
  output logic [1:0]             pc_sel,
  output logic                   epc_we,
  output logic                   epc_src,
  output logic [1:0]             cause,
  output logic                   kernel,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              kernel_nxt;
  logic              irq_pend, irq_pend_nxt;
  logic              irq_take;

  // Priority mux and FSM next-state; reset forces the idle pipeline controls.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_sel       = PCSEL_SEQ;
    epc_we       = 1'b0;
    epc_src      = 1'b0;
    cause        = CAUSE_NONE;
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    kernel_nxt   = kernel;
    irq_take     = 1'b0;

    if (reset) begin
      state_nxt = ST_RUN;
      wait_nxt  = '0;
    end else if (state == ST_BUS_ERR) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      pc_sel       = PCSEL_TRAP;
      epc_we       = 1'b1;
      epc_src      = 1'b0;
      cause        = CAUSE_BUS;
      kernel_nxt   = 1'b1;
      state_nxt    = ST_RUN;
      wait_nxt     = '0;
    end else if ((state == ST_FREEZE) && mem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      ex_mem_we = 1'b0;
      if (wait_cnt == WAIT_LAST) begin
        state_nxt = ST_BUS_ERR;
        wait_nxt  = '0;
      end else begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
    end else begin
      // RUN, or FREEZE releasing this cycle: RUN priorities apply immediately.
      state_nxt = ST_RUN;
      wait_nxt  = '0;
      if (mem_busy) begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        ex_mem_we = 1'b0;
        state_nxt = ST_FREEZE;
        wait_nxt  = WAIT_W'(1);
      end else if (exception_ex) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        pc_sel       = PCSEL_TRAP;
        epc_we       = 1'b1;
        epc_src      = 1'b0;
        cause        = CAUSE_EXC;
        kernel_nxt   = 1'b1;
      end else if (irq_pend && !kernel && !branch_taken && !jump_id) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pc_sel      = PCSEL_TRAP;
        epc_we      = 1'b1;
        epc_src     = 1'b1;
        cause       = CAUSE_IRQ;
        kernel_nxt  = 1'b1;
        irq_take    = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pc_sel      = PCSEL_BR;
      end else if (eret_id && kernel) begin
        if_id_flush = 1'b1;
        pc_sel      = PCSEL_EPC;
        kernel_nxt  = 1'b0;
      end else if (jump_id) begin
        if_id_flush = 1'b1;
        pc_sel      = PCSEL_BR;
      end else if (load_use_stall) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // A pending irq survives kernel-mode periods and is only dropped once taken.
  assign irq_pend_nxt = irq_take ? 1'b0 : (irq_pend | (irq & ~kernel));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      kernel   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      kernel   <= kernel_nxt;
      irq_pend <= irq_pend_nxt;
    end
  end

  stall_perf_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_we),
    .count (stall_cnt)
  );

endmodule
